// File: rtl/layer_color_mapper_if.sv
// Pixel-stream bus for layer_color_mapper: the incoming pixel, its layer
// description, the palette write port and the registered colour output.
interface layer_color_mapper_if #(
    parameter int NUM_LAYERS = 8,
    parameter int IDX_W      = 4,
    parameter int COLOR_W    = 8
);
    logic                        frame_start;
    logic                        pix_valid;
    logic [9:0]                  DrawX;
    logic [9:0]                  DrawY;
    logic [NUM_LAYERS-1:0]       layer_hit;
    logic [NUM_LAYERS*IDX_W-1:0] layer_idx;
    logic [NUM_LAYERS-1:0]       blink_en;
    logic                        pal_we;
    logic [IDX_W-1:0]            pal_waddr;
    logic [3*COLOR_W-1:0]        pal_wdata;
    logic [COLOR_W-1:0]          VGA_R;
    logic [COLOR_W-1:0]          VGA_G;
    logic [COLOR_W-1:0]          VGA_B;
    logic                        out_valid;
    logic [9:0]                  out_X;
    logic [9:0]                  out_Y;

    // Pixel source / palette loader side
    modport master (
        output frame_start, pix_valid, DrawX, DrawY, layer_hit, layer_idx,
               blink_en, pal_we, pal_waddr, pal_wdata,
        input  VGA_R, VGA_G, VGA_B, out_valid, out_X, out_Y
    );

    // Colour mapper side
    modport slave (
        input  frame_start, pix_valid, DrawX, DrawY, layer_hit, layer_idx,
               blink_en, pal_we, pal_waddr, pal_wdata,
        output VGA_R, VGA_G, VGA_B, out_valid, out_X, out_Y
    );
endinterface

// File: rtl/layer_color_mapper.sv
// Layer colour mapper: picks the highest-priority visible layer per pixel
// (layer 0 wins), looks its index up in a writable palette and registers
// the colour. Two-stage pipeline, one pixel per cycle, frame-based blink.
module layer_color_mapper #(
    parameter int                     NUM_LAYERS   = 8,
    parameter int                     IDX_W        = 4,
    parameter int                     COLOR_W      = 8,
    parameter int                     BLINK_FRAMES = 30,
    parameter logic [3*COLOR_W-1:0]   BG_COLOR     = 24'hADFFF0
) (
    input logic                Clk,
    input logic                Reset_n,
    layer_color_mapper_if.slave bus
);
    localparam int unsigned PAL_DEPTH  = 2**IDX_W;
    localparam int unsigned NL         = NUM_LAYERS;
    localparam int          RGB_W      = 3*COLOR_W;
    localparam logic [7:0]  LAST_FRAME = 8'(BLINK_FRAMES - 1);

    logic [7:0]             frame_cnt;
    logic                   blink_phase;
    logic [RGB_W-1:0]       palette [PAL_DEPTH];

    logic [NUM_LAYERS-1:0]  visible;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_found;

    logic                   s1_valid;
    logic                   s1_bg;
    logic [IDX_W-1:0]       s1_idx;
    logic [9:0]             s1_x;
    logic [9:0]             s1_y;

    logic [RGB_W-1:0]       lookup;
    logic [RGB_W-1:0]       out_rgb;

    // Blinking layers are masked out while blink_phase is 1
    always_comb begin
        visible = bus.layer_hit & ~(bus.blink_en & {NUM_LAYERS{blink_phase}});
    end

    // Priority select: lowest-numbered visible layer wins
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < NL; i++) begin
            if (visible[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = bus.layer_idx[i*IDX_W +: IDX_W];
            end
        end
    end

    // Frame counter and blink phase, advanced only on frame_start
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (bus.frame_start) begin
            if (frame_cnt == LAST_FRAME) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Palette storage; cleared by reset, writes ignored while in reset
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < PAL_DEPTH; i++) begin
                palette[i] <= '0;
            end
        end else if (bus.pal_we) begin
            palette[bus.pal_waddr] <= bus.pal_wdata;
        end
    end

    // Asynchronous read sampled at the same edge as a write: old data wins
    always_comb begin
        lookup = palette[s1_idx];
    end

    // Stage 1: register selection result and pixel position
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s1_bg    <= 1'b0;
            s1_idx   <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= bus.pix_valid;
            s1_bg    <= ~sel_found;
            s1_idx   <= sel_idx;
            s1_x     <= bus.DrawX;
            s1_y     <= bus.DrawY;
        end
    end

    // Stage 2: colour resolve with blanking for invalid pixels
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            out_rgb       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_X     <= '0;
            bus.out_Y     <= '0;
        end else begin
            bus.out_valid <= s1_valid;
            bus.out_X     <= s1_x;
            bus.out_Y     <= s1_y;
            if (!s1_valid) begin
                out_rgb <= '0;
            end else if (s1_bg) begin
                out_rgb <= BG_COLOR;
            end else begin
                out_rgb <= lookup;
            end
        end
    end

    assign bus.VGA_R = out_rgb[3*COLOR_W-1 -: COLOR_W];
    assign bus.VGA_G = out_rgb[2*COLOR_W-1 -: COLOR_W];
    assign bus.VGA_B = out_rgb[COLOR_W-1   -: COLOR_W];
endmodule

// File: tb/tb_layer_color_mapper.sv
// Directed bench for layer_color_mapper: vector table for the combinational
// selection path plus hand sequences for blink, collision, reset and ramp.
module tb_layer_color_mapper;
    logic Clk;
    logic Reset_n;
    int   checks;
    int   errors;

    layer_color_mapper_if #(.NUM_LAYERS(8), .IDX_W(4), .COLOR_W(8)) bus ();

    layer_color_mapper #(
        .NUM_LAYERS(8),
        .IDX_W(4),
        .COLOR_W(8),
        .BLINK_FRAMES(2),
        .BG_COLOR(24'hADFFF0)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0]  hit;
        logic [31:0] idx;
        logic [7:0]  blink;
        logic        pv;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
        logic        ov;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rgb_out();
        return {8'h00, bus.VGA_R, bus.VGA_G, bus.VGA_B};
    endfunction

    task automatic pal_write(input logic [3:0] addr, input logic [23:0] data);
        bus.pal_we    = 1'b1;
        bus.pal_waddr = addr;
        bus.pal_wdata = data;
        step();
        bus.pal_we    = 1'b0;
    endtask

    task automatic set_pixel(input logic [7:0] hit, input logic [31:0] idx,
                             input logic [7:0] blink, input logic pv);
        bus.layer_hit = hit;
        bus.layer_idx = idx;
        bus.blink_en  = blink;
        bus.pix_valid = pv;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{8'h24, 32'h0030_0500, 8'h00, 1'b1, 10'd10,  10'd20,  24'h000000, 1'b1};
        vecs[1] = '{8'h20, 32'h0030_0000, 8'h00, 1'b1, 10'd11,  10'd21,  24'hFF69B4, 1'b1};
        vecs[2] = '{8'h00, 32'h0000_0000, 8'h00, 1'b1, 10'd12,  10'd22,  24'hADFFF0, 1'b1};
        vecs[3] = '{8'hFF, 32'h0000_0000, 8'h00, 1'b0, 10'd13,  10'd23,  24'h000000, 1'b0};
        vecs[4] = '{8'h80, 32'h2000_0000, 8'h00, 1'b1, 10'd639, 10'd479, 24'h00FF00, 1'b1};
        vecs[5] = '{8'h03, 32'h0000_0021, 8'h00, 1'b1, 10'd0,   10'd0,   24'hFF0000, 1'b1};
        vecs[6] = '{8'h02, 32'h0000_0030, 8'h02, 1'b1, 10'd300, 10'd200, 24'hFF69B4, 1'b1};
        vecs[7] = '{8'h01, 32'h0000_0009, 8'h00, 1'b1, 10'd1,   10'd2,   24'h000000, 1'b1};

        Reset_n         = 1'b0;
        bus.frame_start = 1'b0;
        bus.DrawX       = 10'd5;
        bus.DrawY       = 10'd6;
        bus.pal_we      = 1'b0;
        bus.pal_waddr   = '0;
        bus.pal_wdata   = '0;
        set_pixel(8'h01, 32'h0, 8'h0, 1'b1);
        repeat (3) step();
        check("reset_rgb",   rgb_out(),     32'h0);
        check("reset_valid", {31'h0, bus.out_valid}, 32'h0);
        check("reset_x",     {22'h0, bus.out_X}, 32'h0);
        check("reset_y",     {22'h0, bus.out_Y}, 32'h0);

        Reset_n = 1'b1;
        set_pixel(8'h00, 32'h0, 8'h0, 1'b0);
        pal_write(4'd3, 24'hFF69B4);
        pal_write(4'd5, 24'h000000);
        pal_write(4'd1, 24'hFF0000);
        pal_write(4'd2, 24'h00FF00);
        pal_write(4'd7, 24'hABCDEF);

        for (int i = 0; i < 8; i++) begin
            set_pixel(vecs[i].hit, vecs[i].idx, vecs[i].blink, vecs[i].pv);
            bus.DrawX = vecs[i].x;
            bus.DrawY = vecs[i].y;
            step();
            step();
            check($sformatf("vec%0d_rgb", i),   rgb_out(), {8'h0, vecs[i].rgb});
            check($sformatf("vec%0d_valid", i), {31'h0, bus.out_valid}, {31'h0, vecs[i].ov});
            check($sformatf("vec%0d_x", i),     {22'h0, bus.out_X}, {22'h0, vecs[i].x});
            check($sformatf("vec%0d_y", i),     {22'h0, bus.out_Y}, {22'h0, vecs[i].y});
        end

        // Blink: layer0 (idx2, 00FF00) blinks over layer1 (idx1, FF0000)
        set_pixel(8'h03, 32'h0000_0012, 8'h01, 1'b1);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        step();
        step();
        check("blink_fs1_shown", rgb_out(), 32'h0000FF00);

        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        step();
        check("blink_fs2_pixel_old_phase", rgb_out(), 32'h0000FF00);
        step();
        check("blink_fs2_hidden", rgb_out(), 32'h00FF0000);

        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b1;
        step();
        step();
        check("blink_fs3_still_hidden", rgb_out(), 32'h00FF0000);

        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b1;
        step();
        step();
        check("blink_fs4_shown_again", rgb_out(), 32'h0000FF00);

        // Write/read collision on palette[7]
        set_pixel(8'h01, 32'h0000_0007, 8'h00, 1'b1);
        step();
        bus.pal_we    = 1'b1;
        bus.pal_waddr = 4'd7;
        bus.pal_wdata = 24'h123456;
        step();
        bus.pal_we    = 1'b0;
        check("collision_old", rgb_out(), 32'h00ABCDEF);
        step();
        check("collision_new", rgb_out(), 32'h00123456);

        // Reset mid-stream, with a palette write that must be ignored
        for (int i = 0; i < 4; i++) begin
            bus.DrawX = 10'(100 + i);
            step();
        end
        check("prereset_valid", {31'h0, bus.out_valid}, 32'h1);
        Reset_n       = 1'b0;
        bus.pal_we    = 1'b1;
        bus.pal_waddr = 4'd7;
        bus.pal_wdata = 24'h777777;
        step();
        check("midreset_rgb",   rgb_out(), 32'h0);
        check("midreset_valid", {31'h0, bus.out_valid}, 32'h0);
        check("midreset_x",     {22'h0, bus.out_X}, 32'h0);
        Reset_n    = 1'b1;
        bus.pal_we = 1'b0;
        step();
        check("release_plus1_valid", {31'h0, bus.out_valid}, 32'h0);
        step();
        check("release_plus2_valid", {31'h0, bus.out_valid}, 32'h1);
        check("release_palette_cleared", rgb_out(), 32'h0);

        // DrawX ramp: output X trails input by two cycles with no gaps
        set_pixel(8'h00, 32'h0, 8'h00, 1'b1);
        for (int i = 0; i <= 640; i++) begin
            bus.DrawX = 10'(i);
            bus.DrawY = 10'd7;
            step();
            if (i >= 1) begin
                check("ramp_x", {22'h0, bus.out_X}, 32'(i - 1));
                check("ramp_valid", {31'h0, bus.out_valid}, 32'h1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
